// File: rtl/debug_sba.sv
// System Bus Access engine: decodes the DMI SB registers and runs one req/ack bus transfer at a time.
// Define SBA_TIMEOUT_EN to abort transfers that get no SYS_ACK/SYS_ERR within TIMEOUT bus cycles.
module debug_sba #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          DMI_CS,
    input  logic          DMI_WR,
    input  logic          DMI_RD,
    input  logic [6:0]    DMI_AD,
    input  logic [31:0]   DMI_DI,
    output logic [31:0]   DMI_DO,
    output logic          SYS_REQ,
    output logic          SYS_WR,
    output logic [AW-1:0] SYS_AD,
    output logic [DW/8-1:0] SYS_ST,
    output logic [DW-1:0] SYS_DO,
    input  logic [DW-1:0] SYS_DI,
    input  logic          SYS_ACK,
    input  logic          SYS_ERR,
    output logic          SBA_BUSY
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    localparam logic [2:0]  MAX_ACC = 3'(OW);
    localparam logic [63:0] AMASK = (AW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] DMASK = (DW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

    typedef enum logic {IDLE, BUS} state_t;
    state_t state_q, state_d;

    logic        busyerr_q, rdonaddr_q, autoinc_q, rdondata_q, bus_wr_q;
    logic [2:0]  access_q, sberr_q, bus_size_q;
    logic [63:0] addr_q, data_q;
    logic [31:0] dmi_do_q;

    logic wr, rd, sel_cs, sel_a0, sel_a1, sel_d0, sel_d1, busy, blocked, busy_viol;
    logic trig_wr, trigger, size_bad, align_bad, start, pre_err, done_ok, done_err, tmo;
    logic [63:0] trig_addr, di64, rmask, rdat, inc;
    logic [7:0]  amask;
    logic [OW-1:0] off;
    logic [NB-1:0] st;
    logic [DW-1:0] wdat;
    logic [31:0] sbcs, rdval;

    assign wr     = DMI_CS & DMI_WR;
    assign rd     = DMI_CS & DMI_RD;
    assign sel_cs = (DMI_AD == 7'h38);
    assign sel_a0 = (DMI_AD == 7'h39);
    assign sel_a1 = (DMI_AD == 7'h3A) && (AW == 64);
    assign sel_d0 = (DMI_AD == 7'h3C);
    assign sel_d1 = (DMI_AD == 7'h3D) && (DW == 64);

    assign busy      = (state_q == BUS);
    assign blocked   = (sberr_q != 3'd0) || busyerr_q;
    assign busy_viol = busy && ((wr && (sel_a0 || sel_a1 || sel_d0 || sel_d1)) || (rd && (sel_d0 || sel_d1)));

    // Triggers only fire from IDLE with no sticky error pending.
    assign trig_wr   = wr && sel_d0 && !busy && !blocked;
    assign trigger   = trig_wr || (wr && sel_a0 && rdonaddr_q && !busy && !blocked)
                               || (rd && sel_d0 && rdondata_q && !busy && !blocked);
    assign trig_addr = (wr && sel_a0) ? {addr_q[63:32], DMI_DI} : addr_q;
    assign amask     = (8'd1 << access_q) - 8'd1;
    assign size_bad  = (access_q > MAX_ACC);
    assign align_bad = ((trig_addr[7:0] & amask) != 8'd0);
    assign start     = trigger && !size_bad && !align_bad;
    assign pre_err   = trigger && (size_bad || align_bad);

    // Handshake: SYS_REQ with SYS_WR/SYS_AD/SYS_ST/SYS_DO is held stable until a cycle where
    // SYS_ACK or SYS_ERR is sampled high; that cycle completes the transfer and REQ drops next.
    assign done_err = busy && SYS_ERR;
    assign done_ok  = busy && SYS_ACK && !SYS_ERR;

`ifdef SBA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    assign tmo = busy && !SYS_ACK && !SYS_ERR && (cnt_q == CW'(TIMEOUT - 1));
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       cnt_q <= '0;
        else if (!busy)   cnt_q <= '0;
        else              cnt_q <= cnt_q + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = BUS;
            BUS:     if (done_ok || done_err || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign off   = addr_q[OW-1:0];
    assign di64  = 64'(SYS_DI);
    assign rmask = (bus_size_q >= 3'd3) ? 64'hFFFF_FFFF_FFFF_FFFF
                                        : ((64'd1 << (7'd8 << bus_size_q)) - 64'd1);
    assign rdat  = (di64 >> {off, 3'b000}) & rmask & DMASK;
    assign inc   = 64'd1 << bus_size_q;

    always_comb begin
        st   = '0;
        wdat = '0;
        for (int i = 0; i < NB; i++) begin
            int nb_i;
            int lane;
            nb_i = 1 << bus_size_q;
            lane = i & (nb_i - 1);
            st[i] = (i >= int'(off)) && (i < int'(off) + nb_i);
            wdat[8*i +: 8] = data_q[8*lane +: 8];
        end
    end

    assign SYS_REQ  = busy;
    assign SYS_WR   = busy & bus_wr_q;
    assign SYS_AD   = busy ? addr_q[AW-1:0] : '0;
    assign SYS_ST   = busy ? st : '0;
    assign SYS_DO   = busy ? wdat : '0;
    assign SBA_BUSY = busy;
    assign DMI_DO   = dmi_do_q;

    assign sbcs = {3'b001, 6'b0, busyerr_q, busy, rdonaddr_q, access_q, autoinc_q, rdondata_q,
                   sberr_q, 7'(AW), 1'b0, (DW == 64), 3'b111};

    always_comb begin
        rdval = 32'd0;
        if (sel_cs)      rdval = sbcs;
        else if (sel_a0) rdval = addr_q[31:0];
        else if (sel_a1) rdval = addr_q[63:32];
        else if (sel_d0) rdval = data_q[31:0];
        else if (sel_d1) rdval = data_q[63:32];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            busyerr_q  <= 1'b0;
            rdonaddr_q <= 1'b0;
            access_q   <= 3'd2;
            autoinc_q  <= 1'b0;
            rdondata_q <= 1'b0;
            sberr_q    <= 3'd0;
            addr_q     <= 64'd0;
            data_q     <= 64'd0;
            bus_wr_q   <= 1'b0;
            bus_size_q <= 3'd0;
            dmi_do_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (rd) dmi_do_q <= rdval;
            if (start) begin
                bus_wr_q   <= trig_wr;
                bus_size_q <= access_q;
            end
            if (wr && !busy) begin
                if (sel_a0) addr_q[31:0]  <= DMI_DI;
                if (sel_a1) addr_q[63:32] <= DMI_DI;
                if (sel_d0) data_q[31:0]  <= DMI_DI;
                if (sel_d1) data_q[63:32] <= DMI_DI;
            end
            if (done_ok) begin
                if (!bus_wr_q) data_q <= rdat;
                if (autoinc_q) addr_q <= (addr_q + inc) & AMASK;
            end
            if (wr && sel_cs) begin
                rdonaddr_q <= DMI_DI[20];
                access_q   <= DMI_DI[19:17];
                autoinc_q  <= DMI_DI[16];
                rdondata_q <= DMI_DI[15];
                sberr_q    <= sberr_q & ~DMI_DI[14:12];
                if (DMI_DI[22]) busyerr_q <= 1'b0;
            end
            // Hardware-set errors override a W1C in the same cycle.
            if (done_err)     sberr_q <= 3'd2;
            else if (tmo)     sberr_q <= 3'd1;
            else if (pre_err) sberr_q <= size_bad ? 3'd4 : 3'd3;
            if (busy_viol) busyerr_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_debug_sba.sv
// Directed bench for debug_sba (AW=32, DW=32, TIMEOUT=8); also covers the SBA_TIMEOUT_EN build.
module tb_debug_sba;
    logic        clk, rst_n;
    logic        dmi_cs, dmi_wr, dmi_rd;
    logic [6:0]  dmi_ad;
    logic [31:0] dmi_di, dmi_do;
    logic        sys_req, sys_wr, sys_ack, sys_err, sba_busy;
    logic [31:0] sys_ad, sys_do, sys_di;
    logic [3:0]  sys_st;
    int n_cmp, n_bad;

    debug_sba #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .CLK(clk), .RST_N(rst_n), .DMI_CS(dmi_cs), .DMI_WR(dmi_wr), .DMI_RD(dmi_rd),
        .DMI_AD(dmi_ad), .DMI_DI(dmi_di), .DMI_DO(dmi_do), .SYS_REQ(sys_req), .SYS_WR(sys_wr),
        .SYS_AD(sys_ad), .SYS_ST(sys_st), .SYS_DO(sys_do), .SYS_DI(sys_di), .SYS_ACK(sys_ack),
        .SYS_ERR(sys_err), .SBA_BUSY(sba_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dmi_cs = 0; dmi_wr = 0; dmi_rd = 0; dmi_ad = '0; dmi_di = '0;
        sys_ack = 0; sys_err = 0; sys_di = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic dmi_write(input logic [6:0] ad, input logic [31:0] di);
        @(negedge clk);
        dmi_cs = 1; dmi_wr = 1; dmi_ad = ad; dmi_di = di;
        @(negedge clk);
        dmi_cs = 0; dmi_wr = 0;
    endtask

    task automatic dmi_read(input logic [6:0] ad, output logic [31:0] data);
        @(negedge clk);
        dmi_cs = 1; dmi_rd = 1; dmi_ad = ad;
        @(negedge clk);
        dmi_cs = 0; dmi_rd = 0;
        data = dmi_do;
    endtask

    // Counts busy cycles from the current negedge; answers in busy cycle n (n=0: never answer).
    task automatic bus_resp(input int n, input logic err, input logic [31:0] di, output int cyc);
        cyc = 0;
        for (int k = 0; k < 100; k++) begin
            if (!sba_busy) break;
            cyc++;
            if (cyc == n) begin
                if (err) sys_err = 1; else sys_ack = 1;
                sys_di = di;
            end
            @(negedge clk);
            sys_ack = 0; sys_err = 0;
        end
    endtask

    initial begin
        logic [31:0] r;
        int cyc;
        n_cmp = 0; n_bad = 0;
        do_reset();

        check("rst_req", sys_req, 0);
        check("rst_busy", sba_busy, 0);
        check("rst_st", sys_st, 0);
        dmi_read(7'h38, r); check("rst_sbcs", r, 32'h2004_0407);

        // word write with autoincrement, ack in the 4th busy cycle
        dmi_write(7'h38, 32'h0005_0000);
        dmi_write(7'h39, 32'h0000_1000);
        dmi_write(7'h3C, 32'hDEAD_BEEF);
        check("t1_req", sys_req, 1);
        check("t1_wr", sys_wr, 1);
        check("t1_ad", sys_ad, 32'h1000);
        check("t1_st", sys_st, 4'hF);
        check("t1_do", sys_do, 32'hDEAD_BEEF);
        bus_resp(4, 0, 0, cyc); check("t1_busy_cycles", cyc, 4);
        dmi_read(7'h39, r); check("t1_addr_inc", r, 32'h1004);
        dmi_read(7'h38, r); check("t1_sbcs", r, 32'h2005_0407);

        // byte read on address write, top lane
        dmi_write(7'h38, 32'h0010_0000);
        dmi_write(7'h39, 32'h0000_2003);
        check("t2_req", sys_req, 1);
        check("t2_wr", sys_wr, 0);
        check("t2_ad", sys_ad, 32'h2003);
        check("t2_st", sys_st, 4'b1000);
        bus_resp(2, 0, 32'hAB00_0000, cyc); check("t2_cycles", cyc, 2);
        dmi_read(7'h3C, r); check("t2_data", r, 32'h0000_00AB);
        dmi_read(7'h39, r); check("t2_no_inc", r, 32'h2003);

        // halfword read from upper half
        dmi_write(7'h38, 32'h0012_0000);
        dmi_write(7'h39, 32'h0000_2002);
        check("hw_st", sys_st, 4'b1100);
        bus_resp(1, 0, 32'h1234_ABCD, cyc);
        dmi_read(7'h3C, r); check("hw_data", r, 32'h0000_1234);

        // byte write replicated across lanes
        dmi_write(7'h38, 32'h0000_0000);
        dmi_write(7'h39, 32'h0000_3001);
        dmi_write(7'h3C, 32'h0000_00A5);
        check("bw_st", sys_st, 4'b0010);
        check("bw_do", sys_do, 32'hA5A5_A5A5);
        bus_resp(1, 0, 0, cyc);

        // misaligned halfword, then W1C
        dmi_write(7'h38, 32'h0002_0000);
        dmi_write(7'h39, 32'h0000_2001);
        dmi_write(7'h3C, 32'h0000_0055);
        check("t3_no_req", sys_req, 0);
        dmi_read(7'h38, r); check("t3_sberr3", r, 32'h2002_3407);
        dmi_write(7'h38, 32'h0002_7000);
        dmi_read(7'h38, r); check("t3_clear", r, 32'h2002_0407);

        // 64-bit access on a 32-bit bus
        dmi_write(7'h38, 32'h0006_0000);
        dmi_write(7'h3C, 32'h0000_0000);
        check("sz_no_req", sys_req, 0);
        dmi_read(7'h38, r); check("sz_sberr4", r, 32'h2006_4407);
        dmi_write(7'h38, 32'h0004_7000);
        dmi_read(7'h38, r); check("sz_clear", r, 32'h2004_0407);

        // busy violation
        dmi_write(7'h39, 32'h0000_4000);
        dmi_write(7'h3C, 32'h1111_1111);
        dmi_write(7'h3C, 32'h2222_2222);
        check("t4_still_busy", sba_busy, 1);
        check("t4_do_kept", sys_do, 32'h1111_1111);
        bus_resp(1, 0, 0, cyc);
        dmi_read(7'h38, r); check("t4_busyerr", r, 32'h2044_0407);
        dmi_read(7'h3C, r); check("t4_data_kept", r, 32'h1111_1111);
        dmi_write(7'h3C, 32'h3333_3333);
        check("t4_blocked", sys_req, 0);
        dmi_write(7'h38, 32'h0044_0000);
        dmi_read(7'h38, r); check("t4_w1c", r, 32'h2004_0407);
        dmi_write(7'h3C, 32'h4444_4444);
        check("t4_resume_req", sys_req, 1);
        check("t4_resume_do", sys_do, 32'h4444_4444);
        bus_resp(1, 0, 0, cyc);

        // bus error on read
        dmi_write(7'h38, 32'h0015_0000);
        dmi_write(7'h39, 32'h0000_5000);
        check("t5_req", sys_req, 1);
        bus_resp(2, 1, 32'hFFFF_FFFF, cyc);
        dmi_read(7'h3C, r); check("t5_data_kept", r, 32'h4444_4444);
        dmi_read(7'h39, r); check("t5_no_inc", r, 32'h5000);
        dmi_read(7'h38, r); check("t5_sberr2", r, 32'h2015_2407);
        dmi_write(7'h38, 32'h0004_7000);

        // read on data
        dmi_write(7'h38, 32'h0004_8000);
        dmi_write(7'h39, 32'h0000_6000);
        check("rod_no_req", sys_req, 0);
        dmi_read(7'h3C, r); check("rod_old", r, 32'h4444_4444);
        check("rod_req", sys_req, 1);
        check("rod_wr", sys_wr, 0);
        bus_resp(1, 0, 32'h7766_5544, cyc);
        dmi_read(7'h3C, r); check("rod_new", r, 32'h7766_5544);
        bus_resp(1, 0, 0, cyc);
        dmi_write(7'h38, 32'h0004_0000);

        // unanswered transfer
        dmi_write(7'h39, 32'h0000_7000);
        dmi_write(7'h3C, 32'h0000_0001);
`ifdef SBA_TIMEOUT_EN
        bus_resp(0, 0, 0, cyc); check("t6_timeout_cycles", cyc, 8);
        check("t6_req", sys_req, 0);
        dmi_read(7'h38, r); check("t6_sberr1", r, 32'h2004_1407);
        dmi_write(7'h38, 32'h0004_7000);
`else
        repeat (20) @(negedge clk);
        check("t6_wait_busy", sba_busy, 1);
        check("t6_wait_req", sys_req, 1);
        bus_resp(1, 0, 0, cyc); check("t6_late_ack", cyc, 1);
        dmi_read(7'h38, r); check("t6_sbcs", r, 32'h2004_0407);
`endif

        // reset mid-transfer
        dmi_write(7'h3C, 32'h0000_0002);
        check("rm_req", sys_req, 1);
        #2 rst_n = 1'b0;
        #1 check("rm_req_drop", sys_req, 0);
        @(negedge clk);
        sys_ack = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sys_ack = 0;
        check("rm_idle", sba_busy, 0);
        dmi_read(7'h38, r); check("rm_sbcs", r, 32'h2004_0407);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
